// File: rtl/countdown_pkg.sv
// Shared definitions for the countdown run controller:
// state encoding, BCD time word layout and digit limits.
package countdown_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } run_state_e;

    localparam logic [3:0] FILLER   = 4'hF;
    localparam logic [3:0] LIM_UNIT = 4'd9;
    localparam logic [3:0] LIM_TENS = 4'd5;

    localparam int HR10_LSB  = 28;
    localparam int HR1_LSB   = 24;
    localparam int FILL1_LSB = 20;
    localparam int MIN10_LSB = 16;
    localparam int MIN1_LSB  = 12;
    localparam int FILL0_LSB = 8;
    localparam int SEC10_LSB = 4;
    localparam int SEC1_LSB  = 0;

    typedef struct packed {
        logic [3:0] hr10;
        logic [3:0] hr1;
        logic [3:0] min10;
        logic [3:0] min1;
        logic [3:0] sec10;
        logic [3:0] sec1;
    } bcd_time_t;

    function automatic bcd_time_t unpack_time(
        input logic [31:0] w
    );
        bcd_time_t t;
        t.hr10  = w[HR10_LSB +: 4];
        t.hr1   = w[HR1_LSB +: 4];
        t.min10 = w[MIN10_LSB +: 4];
        t.min1  = w[MIN1_LSB +: 4];
        t.sec10 = w[SEC10_LSB +: 4];
        t.sec1  = w[SEC1_LSB +: 4];
        return t;
    endfunction

    function automatic logic [31:0] pack_time(
        input bcd_time_t t
    );
        logic [31:0] w;
        w = '0;
        w[HR10_LSB +: 4]  = t.hr10;
        w[HR1_LSB +: 4]   = t.hr1;
        w[FILL1_LSB +: 4] = FILLER;
        w[MIN10_LSB +: 4] = t.min10;
        w[MIN1_LSB +: 4]  = t.min1;
        w[FILL0_LSB +: 4] = FILLER;
        w[SEC10_LSB +: 4] = t.sec10;
        w[SEC1_LSB +: 4]  = t.sec1;
        return w;
    endfunction

    function automatic logic [3:0] sat_digit(
        input logic [3:0] d,
        input logic [3:0] lim
    );
        return (d > lim) ? lim : d;
    endfunction

    function automatic bcd_time_t saturate(
        input bcd_time_t t
    );
        bcd_time_t s;
        s.hr10  = sat_digit(t.hr10, LIM_UNIT);
        s.hr1   = sat_digit(t.hr1, LIM_UNIT);
        s.min10 = sat_digit(t.min10, LIM_TENS);
        s.min1  = sat_digit(t.min1, LIM_UNIT);
        s.sec10 = sat_digit(t.sec10, LIM_TENS);
        s.sec1  = sat_digit(t.sec1, LIM_UNIT);
        return s;
    endfunction

endpackage

// File: rtl/bcd_time_dec.sv
// Combinational HH:MM:SS BCD decrement by one second.
// Borrow ripples sec -> min -> hr; hours run 00..99.
module bcd_time_dec
    import countdown_pkg::*;
(
    input  bcd_time_t t,
    output bcd_time_t q,
    output logic      is_zero
);

    logic b_s1, b_s10, b_m1, b_m10, b_h1;

    always_comb begin
        b_s1  = (t.sec1 == 4'd0);
        b_s10 = b_s1 && (t.sec10 == 4'd0);
        b_m1  = b_s10 && (t.min1 == 4'd0);
        b_m10 = b_m1 && (t.min10 == 4'd0);
        b_h1  = b_m10 && (t.hr1 == 4'd0);

        q.sec1 = b_s1 ? LIM_UNIT : t.sec1 - 4'd1;

        q.sec10 = t.sec10;
        if (b_s1)
            q.sec10 = (t.sec10 == 4'd0) ? LIM_TENS
                                        : t.sec10 - 4'd1;

        q.min1 = t.min1;
        if (b_s10)
            q.min1 = (t.min1 == 4'd0) ? LIM_UNIT
                                      : t.min1 - 4'd1;

        q.min10 = t.min10;
        if (b_m1)
            q.min10 = (t.min10 == 4'd0) ? LIM_TENS
                                        : t.min10 - 4'd1;

        q.hr1 = t.hr1;
        if (b_m10)
            q.hr1 = (t.hr1 == 4'd0) ? LIM_UNIT
                                    : t.hr1 - 4'd1;

        q.hr10 = t.hr10;
        if (b_h1)
            q.hr10 = (t.hr10 == 4'd0) ? LIM_UNIT
                                      : t.hr10 - 4'd1;
    end

    assign is_zero = (q == '0);

endmodule

// File: rtl/countdown_run_ctrl.sv
// Countdown run controller: load, 1 Hz BCD decrement,
// pause/resume, clear and timed expiry alarm.
module countdown_run_ctrl
    import countdown_pkg::*;
#(
    parameter int CLK_HZ    = 100_000_000,
    parameter int ALARM_SEC = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        active,
    input  logic [31:0] preset,
    input  logic        preset_busy,
    input  logic        start_stop,
    input  logic        clear,
    output logic [31:0] disp,
    output logic [1:0]  run_state,
    output logic        done,
    output logic        alarm
);

    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int AW = $clog2(ALARM_SEC + 1);
    localparam logic [PW-1:0] P_LAST = PW'(CLK_HZ - 1);
    localparam logic [AW-1:0] A_LAST = AW'(ALARM_SEC - 1);

    run_state_e    state_q, state_d;
    bcd_time_t     rem_q, rem_dec, preset_t;
    logic          dec_zero;
    logic [PW-1:0] presc_q;
    logic [AW-1:0] acnt_q;
    logic          done_q, alarm_q;

    logic ss, tick, preset_nz;
    logic load, dec_en, wipe, done_d, alarm_d;

    assign ss        = start_stop && active;
    assign preset_t  = unpack_time(preset);
    assign preset_nz = |preset_t;
    assign tick      = (state_q == ST_RUN ||
                        state_q == ST_DONE) &&
                       (presc_q == P_LAST);

    bcd_time_dec u_dec (
        .t       (rem_q),
        .q       (rem_dec),
        .is_zero (dec_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (ss && !preset_busy && preset_nz)
                    state_d = ST_RUN;
            end
            ST_RUN: begin
                if (clear)
                    state_d = ST_IDLE;
                else if (tick && dec_zero)
                    state_d = ST_DONE;
                else if (ss)
                    state_d = ST_PAUSE;
            end
            ST_PAUSE: begin
                if (clear)
                    state_d = ST_IDLE;
                else if (ss)
                    state_d = ST_RUN;
            end
            ST_DONE: begin
                if (clear || ss)
                    state_d = ST_IDLE;
                else if (tick && acnt_q == A_LAST)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        load    = (state_q == ST_IDLE) &&
                  (state_d == ST_RUN);
        dec_en  = (state_q == ST_RUN) && tick && !clear;
        wipe    = clear && (state_q != ST_IDLE);
        done_d  = (state_q == ST_RUN) &&
                  (state_d == ST_DONE);
        alarm_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rem_q <= '0;
        else if (wipe)
            rem_q <= '0;
        else if (load)
            rem_q <= saturate(preset_t);
        else if (dec_en)
            rem_q <= rem_dec;
    end

    // Prescaler only advances in RUN and DONE, so PAUSE holds it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            presc_q <= '0;
        else if (load || wipe || tick)
            presc_q <= '0;
        else if (state_q == ST_RUN || state_q == ST_DONE)
            presc_q <= presc_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            acnt_q <= '0;
        else if (state_q != ST_DONE)
            acnt_q <= '0;
        else if (tick)
            acnt_q <= acnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q  <= 1'b0;
            alarm_q <= 1'b0;
        end else begin
            done_q  <= done_d;
            alarm_q <= alarm_d;
        end
    end

    assign disp      = (state_q == ST_IDLE) ? preset
                                            : pack_time(rem_q);
    assign run_state = state_q;
    assign done      = done_q;
    assign alarm     = alarm_q;

endmodule

// File: tb/tb_countdown_run_ctrl.sv
// Scoreboard bench for countdown_run_ctrl: stimulus queues
// cycle-stamped expectations, a monitor compares them.
module tb_countdown_run_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        active;
    logic [31:0] preset;
    logic        preset_busy;
    logic        start_stop;
    logic        clear;
    logic [31:0] disp;
    logic [1:0]  run_state;
    logic        done;
    logic        alarm;

    countdown_run_ctrl #(
        .CLK_HZ    (10),
        .ALARM_SEC (3)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .active      (active),
        .preset      (preset),
        .preset_busy (preset_busy),
        .start_stop  (start_stop),
        .clear       (clear),
        .disp        (disp),
        .run_state   (run_state),
        .done        (done),
        .alarm       (alarm)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        int          kind;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   dq[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] tw(
        input logic [3:0] a, b, c, d, e, f
    );
        return {a, b, 4'hF, c, d, 4'hF, e, f};
    endfunction

    function automatic logic [31:0] act(input int k);
        case (k)
            0:       return disp;
            1:       return {30'd0, run_state};
            2:       return {31'd0, alarm};
            default: return {31'd0, done};
        endcase
    endfunction

    function automatic string kname(input int k);
        case (k)
            0:       return "disp";
            1:       return "run_state";
            2:       return "alarm";
            default: return "done";
        endcase
    endfunction

    task automatic expect_at(
        input int c, input int k, input logic [31:0] v
    );
        exp_t e;
        e.cyc = c;
        e.kind = k;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic chk_now(
        input string nm,
        input logic [31:0] a,
        input logic [31:0] e
    );
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, a, e);
        end
    endtask

    // Monitor: compares queued expectations at their cycle
    // and every done pulse against the expected pulse cycle.
    initial begin
        exp_t e;
        int   dc;
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                n_cmp++;
                if (e.cyc < cyc) begin
                    n_bad++;
                    $display("FAIL %s: check for cycle %0d missed",
                             kname(e.kind), e.cyc);
                end else if (act(e.kind) !== e.val) begin
                    n_bad++;
                    $display("FAIL %s @%0d: got %h expected %h",
                             kname(e.kind), cyc,
                             act(e.kind), e.val);
                end
            end
            if (rst_n === 1'b1 && done === 1'b1) begin
                n_cmp++;
                if (dq.size() == 0) begin
                    n_bad++;
                    $display("FAIL done: pulse @%0d expected none",
                             cyc);
                end else begin
                    dc = dq.pop_front();
                    if (dc != cyc) begin
                        n_bad++;
                        $display("FAIL done: pulse @%0d expected @%0d",
                                 cyc, dc);
                    end
                end
            end
        end
    end

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic fire_ss(output int l);
        l = cyc + 1;
        start_stop = 1'b1;
    endtask

    task automatic fire_clr(output int l);
        l = cyc + 1;
        clear = 1'b1;
    endtask

    task automatic rel();
        @(negedge clk);
        start_stop = 1'b0;
        clear = 1'b0;
    endtask

    task automatic clear_to_idle();
        int c;
        fire_clr(c);
        expect_at(c, 1, 32'd0);
        expect_at(c, 0, preset);
        rel();
        wait_cyc(c + 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit hit");
        $fatal(1, "watchdog");
    end

    initial begin
        int L, P, R, C;
        logic [31:0] w8;
        rst_n = 1'b0;
        active = 1'b1;
        preset_busy = 1'b0;
        start_stop = 1'b0;
        clear = 1'b0;
        preset = tw(0, 0, 0, 0, 0, 3);

        #3;
        chk_now("rst_alarm", {31'd0, alarm}, 32'd0);
        chk_now("rst_done", {31'd0, done}, 32'd0);
        chk_now("rst_state", {30'd0, run_state}, 32'd0);
        chk_now("rst_disp", disp, tw(0, 0, 0, 0, 0, 3));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        expect_at(cyc + 1, 1, 32'd0);
        expect_at(cyc + 1, 2, 32'd0);
        @(negedge clk);

        // Basic expiry from 00:00:03
        fire_ss(L);
        expect_at(L, 1, 32'd1);
        expect_at(L, 0, tw(0, 0, 0, 0, 0, 3));
        expect_at(L + 9, 0, tw(0, 0, 0, 0, 0, 3));
        expect_at(L + 10, 0, tw(0, 0, 0, 0, 0, 2));
        expect_at(L + 20, 0, tw(0, 0, 0, 0, 0, 1));
        expect_at(L + 30, 0, tw(0, 0, 0, 0, 0, 0));
        expect_at(L + 30, 1, 32'd3);
        expect_at(L + 30, 2, 32'd1);
        expect_at(L + 59, 1, 32'd3);
        expect_at(L + 59, 2, 32'd1);
        expect_at(L + 60, 1, 32'd0);
        expect_at(L + 60, 2, 32'd0);
        expect_at(L + 61, 0, tw(0, 0, 0, 0, 0, 3));
        dq.push_back(L + 30);
        rel();
        wait_cyc(L + 62);

        // Borrow chains
        preset = tw(0, 1, 0, 0, 0, 0);
        fire_ss(L);
        expect_at(L + 9, 0, tw(0, 1, 0, 0, 0, 0));
        expect_at(L + 10, 0, tw(0, 0, 5, 9, 5, 9));
        rel();
        wait_cyc(L + 12);
        clear_to_idle();

        preset = tw(1, 0, 0, 0, 0, 0);
        fire_ss(L);
        expect_at(L + 10, 0, tw(0, 9, 5, 9, 5, 9));
        rel();
        wait_cyc(L + 12);
        clear_to_idle();

        // Pause / resume
        preset = tw(0, 0, 0, 0, 0, 9);
        w8 = tw(0, 0, 0, 0, 0, 8);
        fire_ss(L);
        expect_at(L + 10, 0, w8);
        rel();
        wait_cyc(L + 14);
        fire_ss(P);
        expect_at(P, 1, 32'd2);
        expect_at(P, 0, w8);
        expect_at(P + 50, 0, w8);
        expect_at(P + 100, 0, w8);
        expect_at(P + 100, 1, 32'd2);
        rel();
        wait_cyc(P + 100);
        fire_ss(R);
        expect_at(R, 1, 32'd1);
        expect_at(R + 4, 0, w8);
        expect_at(R + 5, 0, tw(0, 0, 0, 0, 0, 7));
        rel();
        wait_cyc(R + 6);
        clear_to_idle();

        // Gating: zero preset, busy, inactive
        for (int g = 0; g < 3; g++) begin
            preset = (g == 0) ? tw(0, 0, 0, 0, 0, 0)
                              : tw(0, 0, 0, 0, 1, 0);
            preset_busy = (g == 1);
            active = (g != 2);
            fire_ss(L);
            expect_at(L, 1, 32'd0);
            expect_at(L, 0, preset);
            expect_at(L + 1, 1, 32'd0);
            rel();
            wait_cyc(L + 2);
        end
        preset_busy = 1'b0;
        active = 1'b1;

        // clear beats start_stop
        preset = tw(0, 0, 0, 0, 0, 5);
        fire_ss(L);
        rel();
        wait_cyc(L + 3);
        C = cyc + 1;
        clear = 1'b1;
        start_stop = 1'b1;
        expect_at(C, 1, 32'd0);
        expect_at(C, 0, preset);
        expect_at(C + 1, 1, 32'd0);
        rel();
        wait_cyc(C + 2);

        // Load saturation: sec_10=7, min_1=C
        preset = 32'h00F0_CF70;
        fire_ss(L);
        expect_at(L, 0, 32'h00F0_9F50);
        expect_at(L + 10, 0, 32'h00F0_9F49);
        rel();
        wait_cyc(L + 12);
        clear_to_idle();

        // Async reset while in DONE
        preset = tw(0, 0, 0, 0, 0, 1);
        fire_ss(L);
        expect_at(L + 10, 1, 32'd3);
        expect_at(L + 10, 2, 32'd1);
        dq.push_back(L + 10);
        rel();
        wait_cyc(L + 15);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_now("async_alarm", {31'd0, alarm}, 32'd0);
        chk_now("async_state", {30'd0, run_state}, 32'd0);
        chk_now("async_disp", disp, tw(0, 0, 0, 0, 0, 1));
        @(negedge clk);
        rst_n = 1'b1;
        expect_at(cyc + 2, 1, 32'd0);
        expect_at(cyc + 2, 2, 32'd0);
        wait_cyc(cyc + 4);

        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL %s: check for cycle %0d never reached",
                     kname(e.kind), e.cyc);
        end
        while (dq.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done: no pulse seen for cycle %0d",
                     dq.pop_front());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
